// File: rtl/reg_file_dump_reader.sv
// Debug read-out engine: walks a register-file address range on a spare read
// port and streams {address, word} pairs over a valid/ready link.
module reg_file_dump_reader #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 100,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             Abort,
    input  logic [AW-1:0]    First_Addr,
    input  logic [AW-1:0]    Last_Addr,
    output logic [AW-1:0]    Rd_Addr,
    input  logic [WIDTH-1:0] Rd_Data,
    output logic [WIDTH-1:0] Out_Data,
    output logic [AW-1:0]    Out_Addr,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic             Out_Last,
    output logic             Busy,
    output logic             Done,
    output logic             Err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [AW-1:0] MAX_ADDR = AW'(DEPTH - 1);

    state_t           state_q, state_d;
    logic [AW-1:0]    rd_addr_q, rd_addr_d;
    logic [AW-1:0]    last_q, last_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [AW-1:0]    out_addr_q, out_addr_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             range_ok_c;

    // Range accepted only if ordered and inside the register file.
    assign range_ok_c = (First_Addr <= Last_Addr) && (Last_Addr <= MAX_ADDR);

    // Next-state and next-output computation; Abort overrides everything else.
    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        last_d      = last_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    if (range_ok_c) begin
                        last_d    = Last_Addr;
                        rd_addr_d = First_Addr;
                        state_d   = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                out_data_d  = Rd_Data;
                out_addr_d  = rd_addr_q;
                out_last_d  = (rd_addr_q == last_q);
                out_valid_d = 1'b1;
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (Out_Ready) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        state_d = S_DONE;
                    end else begin
                        rd_addr_d = rd_addr_q + AW'(1);
                        state_d   = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                out_last_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (Abort) begin
            state_d     = S_IDLE;
            rd_addr_d   = rd_addr_q;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            err_d       = 1'b0;
        end

        busy_d = (state_d == S_LOAD) || (state_d == S_SEND);
        done_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= S_IDLE;
            rd_addr_q   <= '0;
            last_q      <= '0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            last_q      <= last_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign Rd_Addr   = rd_addr_q;
    assign Out_Data  = out_data_q;
    assign Out_Addr  = out_addr_q;
    assign Out_Valid = out_valid_q;
    assign Out_Last  = out_last_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Err       = err_q;

endmodule

// File: tb/tb_reg_file_dump_reader.sv
// Bench for reg_file_dump_reader: table of dump runs plus abort/reset sequences.
module tb_reg_file_dump_reader;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 100;
    localparam int unsigned AW    = 7;

    logic             Clk = 1'b0;
    logic             Rst = 1'b1;
    logic             Start = 1'b0;
    logic             Abort = 1'b0;
    logic [AW-1:0]    First_Addr = '0;
    logic [AW-1:0]    Last_Addr = '0;
    logic [AW-1:0]    Rd_Addr;
    logic [WIDTH-1:0] Rd_Data;
    logic [WIDTH-1:0] Out_Data;
    logic [AW-1:0]    Out_Addr;
    logic             Out_Valid;
    logic             Out_Ready = 1'b0;
    logic             Out_Last;
    logic             Busy;
    logic             Done;
    logic             Err;

    logic [WIDTH-1:0] regs [DEPTH];

    int checks = 0;
    int errors = 0;
    int first_valid_n, second_valid_n, done_n;
    logic [WIDTH-1:0] cap8;

    reg_file_dump_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Abort(Abort),
        .First_Addr(First_Addr), .Last_Addr(Last_Addr),
        .Rd_Addr(Rd_Addr), .Rd_Data(Rd_Data),
        .Out_Data(Out_Data), .Out_Addr(Out_Addr), .Out_Valid(Out_Valid),
        .Out_Ready(Out_Ready), .Out_Last(Out_Last),
        .Busy(Busy), .Done(Done), .Err(Err)
    );

    always #5 Clk = ~Clk;

    // Combinational register-file read port model.
    assign Rd_Data = (int'(Rd_Addr) < DEPTH) ? regs[int'(Rd_Addr)] : '0;

    typedef struct {
        int first;
        int last;
        int stall;
        bit exp_err;
        int exp_words;
        int action;   // 0 none, 1 write r8 mid-dump, 2 Start mid-dump
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({Rd_Addr, Out_Data, Out_Addr, Out_Valid, Out_Last, Busy, Done, Err});
    endfunction

    task automatic run_dump(input int first, input int last, input int stall,
                            input bit exp_err, input int exp_words, input int action);
        int n;
        int words;
        int guard;
        int a;
        logic [WIDTH-1:0] exp_data;
        n = 0;
        words = 0;
        Out_Ready = 1'b0;
        First_Addr = AW'(first);
        Last_Addr = AW'(last);
        Start = 1'b1;
        tick(); n++;
        Start = 1'b0;
        if (exp_err) begin
            check("err_pulse", 64'(Err), 64'd1);
            check("err_busy", 64'(Busy), 64'd0);
            tick();
            check("err_one_cycle", 64'({Err, Busy}), 64'd0);
            return;
        end
        a = first;
        while (a <= last) begin
            guard = 0;
            while (!Out_Valid && guard < 10) begin
                tick(); n++; guard++;
            end
            if (!Out_Valid) begin
                check("valid_timeout", 64'(Out_Valid), 64'd1);
                return;
            end
            if (words == 0) first_valid_n = n;
            if (words == 1) second_valid_n = n;
            exp_data = regs[a];
            check("word_addr", 64'(Out_Addr), 64'(a));
            check("word_data", 64'(Out_Data), 64'(exp_data));
            check("word_last", 64'(Out_Last), 64'(a == last));
            check("word_busy_nodone", 64'({Busy, Done}), 64'b10);
            if (a == 8) cap8 = Out_Data;
            if (action == 1 && a == 2) regs[8] = 32'hA5A5A5A5;
            if (action == 2 && a == 3) begin
                First_Addr = AW'(50);
                Last_Addr = AW'(60);
                Start = 1'b1;
                tick(); n++;
                Start = 1'b0;
                check("start_ignored", 64'({Err, Out_Valid, Out_Addr}), 64'({1'b0, 1'b1, AW'(3)}));
            end
            for (int s = 0; s < stall; s++) begin
                tick(); n++;
                check("stall_stable", 64'({Out_Valid, Out_Last, Out_Addr, Out_Data}),
                      64'({1'b1, a == last, AW'(a), exp_data}));
            end
            Out_Ready = 1'b1;
            tick(); n++;
            Out_Ready = 1'b0;
            words++;
            a++;
        end
        check("word_count", 64'(words), 64'(exp_words));
        done_n = n;
        check("done_pulse", 64'({Done, Out_Valid}), 64'b10);
        tick();
        check("after_done", 64'({Done, Busy, Out_Valid, Out_Last}), 64'd0);
    endtask

    // Start 10..20, stop at address 13 with Abort or Rst, then run 0..0.
    task automatic abort_seq(input bit use_rst);
        int guard;
        bit bad;
        First_Addr = AW'(10);
        Last_Addr = AW'(20);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int a = 10; a <= 13; a++) begin
            guard = 0;
            while (!Out_Valid && guard < 10) begin
                tick(); guard++;
            end
            check("abort_walk_addr", 64'({Out_Valid, Out_Addr}), 64'({1'b1, AW'(a)}));
            if (a < 13) begin
                Out_Ready = 1'b1;
                tick();
                Out_Ready = 1'b0;
            end
        end
        Out_Ready = 1'b1;
        if (use_rst) Rst = 1'b1;
        else Abort = 1'b1;
        tick();
        Rst = 1'b0;
        Abort = 1'b0;
        Out_Ready = 1'b0;
        if (use_rst) check("rst_mid_all_zero", all_outs(), 64'd0);
        else check("abort_outs", 64'({Out_Valid, Out_Last, Busy, Done, Err}), 64'd0);
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (Done || Out_Valid || Busy || Err) bad = 1'b1;
        end
        check("abort_quiet", 64'(bad), 64'd0);
        run_dump(0, 0, 0, 1'b0, 1, 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) regs[i] = 32'h1000_0000 + 32'(i * 32'h0101);
        regs[5] = 32'hDEADBEEF;
        regs[6] = 32'h12345678;

        vecs[0] = '{first: 5,  last: 6,   stall: 0, exp_err: 1'b0, exp_words: 2,  action: 0};
        vecs[1] = '{first: 0,  last: 2,   stall: 3, exp_err: 1'b0, exp_words: 3,  action: 0};
        vecs[2] = '{first: 99, last: 99,  stall: 0, exp_err: 1'b0, exp_words: 1,  action: 0};
        vecs[3] = '{first: 7,  last: 3,   stall: 0, exp_err: 1'b1, exp_words: 0,  action: 0};
        vecs[4] = '{first: 0,  last: 100, stall: 0, exp_err: 1'b1, exp_words: 0,  action: 0};
        vecs[5] = '{first: 0,  last: 0,   stall: 1, exp_err: 1'b0, exp_words: 1,  action: 0};
        vecs[6] = '{first: 97, last: 99,  stall: 1, exp_err: 1'b0, exp_words: 3,  action: 0};
        vecs[7] = '{first: 0,  last: 9,   stall: 0, exp_err: 1'b0, exp_words: 10, action: 1};
        vecs[8] = '{first: 0,  last: 9,   stall: 0, exp_err: 1'b0, exp_words: 10, action: 2};

        Rst = 1'b1;
        tick();
        tick();
        check("reset_all_zero", all_outs(), 64'd0);
        Rst = 1'b0;
        tick();

        for (int v = 0; v < 9; v++) begin
            first_valid_n = -1;
            second_valid_n = -1;
            done_n = -1;
            cap8 = '0;
            run_dump(vecs[v].first, vecs[v].last, vecs[v].stall,
                     vecs[v].exp_err, vecs[v].exp_words, vecs[v].action);
            if (v == 0) begin
                check("first_valid_cycle", 64'(first_valid_n), 64'd2);
                check("second_valid_cycle", 64'(second_valid_n), 64'd4);
                check("done_cycle", 64'(done_n), 64'd5);
            end
            if (v == 7) check("coherence_r8", 64'(cap8), 64'h00000000A5A5A5A5);
            tick();
        end

        abort_seq(1'b0);
        tick();
        abort_seq(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
